// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, guards memory wait-states with a timeout, counts retirements.
module multicycle_controller #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [6:0]           op,
    input  logic                 Zero,
    input  logic                 memReady,
    output logic                 memReq,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ResultSrc,
    output logic                 illegalInstr,
    output logic                 memFault,
    output logic [CNT_WIDTH-1:0] instret,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11
    } state_t;

    typedef struct packed {
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] resultsrc;
        logic       memreq;
        logic       fetch;
        logic       jal;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
    } ctrl_t;

    localparam int            WW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] TMO    = WW'(MEM_TIMEOUT);
    localparam logic          TMO_EN = (MEM_TIMEOUT != 0);

    state_t                 state_reg, state_next;
    ctrl_t                  ctrl_reg;
    logic [WW-1:0]          wait_cnt_reg;
    logic [CNT_WIDTH-1:0]   instret_reg;
    logic                   retire_next;
    logic                   illegal_next;
    logic                   timeout_hit;
    logic                   fault;

    // Moore decode of a state; loaded together with the state so the selects come from flops.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memreq = 1'b1; c.fetch = 1'b1;
                c.alusrcb = 2'b10; c.resultsrc = 2'b10;
            end
            S_DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
            S_MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
            S_MEMREAD:  begin c.memreq = 1'b1; c.adrsrc = 1'b1; end
            S_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
            S_MEMWRITE: begin c.memreq = 1'b1; c.adrsrc = 1'b1; c.memwrite = 1'b1; end
            S_EXECR:    begin c.alusrca = 2'b10; c.alusrcb = 2'b00; c.aluop = 2'b10; end
            S_EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
            S_ALUWB:    begin c.regwrite = 1'b1; end
            S_BRANCH:   begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
            S_JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.jal = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    // Only the memory states carry memreq, so it doubles as the "waiting on memory" flag.
    assign timeout_hit = TMO_EN & ctrl_reg.memreq & ~memReady & (wait_cnt_reg == TMO);

    always_comb begin
        state_next   = state_reg;
        retire_next  = 1'b0;
        illegal_next = 1'b0;
        case (state_reg)
            S_RESET:  state_next = S_FETCH;
            S_FETCH: begin
                if (memReady)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_next = S_MEMADR;
                    7'b0110011:             state_next = S_EXECR;
                    7'b0010011:             state_next = S_EXECI;
                    7'b1100011:             state_next = S_BRANCH;
                    7'b1101111:             state_next = S_JAL;
                    default: begin
                        state_next   = S_FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (memReady)
                    state_next = S_MEMWB;
                else if (timeout_hit)
                    state_next = S_FETCH;
            end
            S_MEMWB: begin
                state_next  = S_FETCH;
                retire_next = 1'b1;
            end
            S_MEMWRITE: begin
                if (memReady) begin
                    state_next  = S_FETCH;
                    retire_next = 1'b1;
                end else if (timeout_hit) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECR, S_EXECI, S_JAL: state_next = S_ALUWB;
            S_ALUWB, S_BRANCH: begin
                state_next  = S_FETCH;
                retire_next = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_RESET;
            ctrl_reg     <= '0;
            wait_cnt_reg <= '0;
            instret_reg  <= '0;
        end else if (en) begin
            state_reg <= state_next;
            ctrl_reg  <= decode_ctrl(state_next);
            // A timeout in FETCH stays in FETCH but must still restart the wait window.
            if (state_next != state_reg || timeout_hit)
                wait_cnt_reg <= '0;
            else if (ctrl_reg.memreq && !memReady)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if (retire_next)
                instret_reg <= instret_reg + 1'b1;
        end
    end

    assign fault        = en & timeout_hit;
    assign memFault     = fault;
    assign illegalInstr = en & illegal_next;
    assign memReq       = en & ctrl_reg.memreq & ~fault;
    assign IRWrite      = en & ctrl_reg.fetch & memReady;
    assign PCWrite      = en & ((ctrl_reg.fetch & memReady) | ctrl_reg.jal | (ctrl_reg.branch & Zero));
    assign RegWrite     = en & ctrl_reg.regwrite;
    assign MemWrite     = en & ctrl_reg.memwrite & ~fault;
    assign AdrSrc       = ctrl_reg.adrsrc;
    assign ALUSrcA      = ctrl_reg.alusrca;
    assign ALUSrcB      = ctrl_reg.alusrcb;
    assign ALUOp        = ctrl_reg.aluop;
    assign ResultSrc    = ctrl_reg.resultsrc;
    assign instret      = instret_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequences with hand-computed state/output expectations.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [6:0] op;
    logic       Zero;
    logic       memReady;
    logic       memReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic       illegalInstr, memFault;
    logic [3:0] instret;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.CNT_WIDTH(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .Zero(Zero), .memReady(memReady),
        .memReq(memReq), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .illegalInstr(illegalInstr),
        .memFault(memFault), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one edge, then leave a settle margin before inputs change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_add();
        op = 7'b0110011; memReady = 1'b1;
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; op = 7'b0110011; Zero = 1'b0; memReady = 1'b0;
        #3;
        check("rst_state", state, 0);
        check("rst_outs", {memReq, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrcB, ResultSrc}, 0);
        check("rst_instret", instret, 0);
        #9 rst_n = 1'b1;
        tick();

        // en=0 in FETCH: frozen, no request
        en = 1'b0; memReady = 1'b1; #1;
        check("hold_memreq", {memReq, IRWrite, PCWrite}, 0);
        tick();
        check("hold_state", state, 1);
        en = 1'b1;

        // add
        #1;
        check("add_fetch_state", state, 1);
        check("add_fetch_en", {memReq, AdrSrc, IRWrite, PCWrite}, 4'b1011);
        check("add_fetch_sel", {ALUSrcA, ALUSrcB, ResultSrc}, 6'b001010);
        tick();
        check("add_decode", {state, ALUSrcA, ALUSrcB, memReq}, {4'd2, 2'b01, 2'b01, 1'b0});
        tick();
        check("add_execr", {state, ALUSrcA, ALUSrcB, ALUOp}, {4'd7, 2'b10, 2'b00, 2'b10});
        tick();
        check("add_aluwb", {state, RegWrite, ResultSrc}, {4'd9, 1'b1, 2'b00});
        check("add_instret_pre", instret, 0);
        tick();
        check("add_done", {state, RegWrite}, {4'd1, 1'b0});
        check("add_instret", instret, 1);

        // lw, memReady late by 3 cycles
        op = 7'b0000011; memReady = 1'b1;
        tick(); tick();
        check("lw_memadr", {state, ALUSrcA, ALUSrcB}, {4'd3, 2'b10, 2'b01});
        tick();
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("lw_wait%0d", i), {state, memReq, AdrSrc, RegWrite}, {4'd4, 3'b110});
            tick();
        end
        memReady = 1'b1; #1;
        check("lw_ready", {state, memReq, AdrSrc}, {4'd4, 2'b11});
        tick();
        check("lw_memwb", {state, RegWrite, ResultSrc, memReq}, {4'd5, 1'b1, 2'b01, 1'b0});
        tick();
        check("lw_instret", {state, instret}, {4'd1, 4'd2});

        // beq taken then not taken
        op = 7'b1100011; Zero = 1'b1;
        tick(); Zero = 1'b0; #1;
        check("beq_decode_pcw", PCWrite, 0);
        tick(); Zero = 1'b1; #1;
        check("beq_z1", {state, PCWrite, ALUOp, ALUSrcA, ALUSrcB}, {4'd10, 1'b1, 2'b01, 2'b10, 2'b00});
        tick();
        Zero = 1'b0;
        tick(); tick(); #1;
        check("beq_z0", {state, PCWrite}, {4'd10, 1'b0});
        tick();
        check("beq_instret", {state, instret}, {4'd1, 4'd4});

        // illegal opcode
        op = 7'b1110011;
        tick(); #1;
        check("ill_pulse", {state, illegalInstr}, {4'd2, 1'b1});
        tick();
        check("ill_back", {state, illegalInstr, instret}, {4'd1, 1'b0, 4'd4});

        // sw with memReady never: fault after 4 waits
        op = 7'b0100011;
        tick(); tick(); tick();
        memReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("sw_wait%0d", i), {state, memReq, MemWrite, memFault}, {4'd6, 3'b110});
            tick();
        end
        #1;
        check("sw_fault", {state, memFault, MemWrite}, {4'd6, 2'b10});
        tick();
        check("sw_fetch", {state, memFault, instret}, {4'd1, 1'b0, 4'd4});

        // jal retires once through ALUWB
        op = 7'b1101111; memReady = 1'b1;
        tick(); tick();
        check("jal", {state, PCWrite, ALUSrcA, ALUSrcB}, {4'd11, 1'b1, 2'b01, 2'b10});
        tick();
        check("jal_aluwb", {state, RegWrite, instret}, {4'd9, 1'b1, 4'd4});
        tick();
        check("jal_instret", {state, instret}, {4'd1, 4'd5});

        // reset mid-MEMWRITE
        op = 7'b0100011;
        tick(); tick(); tick();
        memReady = 1'b0; #1;
        check("rmw_pre", {state, MemWrite}, {4'd6, 1'b1});
        #2 rst_n = 1'b0; #1;
        check("rmw_outs", {memReq, MemWrite, RegWrite, PCWrite, IRWrite}, 0);
        check("rmw_state", {state, instret}, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        tick();
        check("rmw_resume", {state, memReq}, {4'd1, 1'b1});

        // instret wrap at CNT_WIDTH=4
        for (int i = 0; i < 15; i++) do_add();
        check("wrap_15", instret, 15);
        do_add();
        check("wrap_0", instret, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
